fft_result_collector: RTL

- Sink on the output side of the 32-point FFT: captures the serial `finish`/`answer` result stream (32 real words, then 32 imaginary words).
- Stores the 64 words as 32 complex bins and holds a full frame until the consumer releases it.
- Presents a random-access, one-cycle-latency read port returning {real, imag} per bin, plus frame status and error flags.
- Replaces testbench-side golden comparison with on-chip capture for host readout.

---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_bin_ram.sv | 38 +++
 rtl/fft_result_collector.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT result collector.
package fft_pkg;

  localparam int unsigned FFT_N       = 32;
  localparam int unsigned FFT_OUT_W   = 17;
  localparam int unsigned FFT_AW      = 5;
  localparam int unsigned FFT_GAP_MAX = 15;
  localparam int unsigned FFT_GAP_W   = $clog2(FFT_GAP_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CAP_RE = 2'd1,
    CAP_IM = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [FFT_OUT_W-1:0] re;
    logic [FFT_OUT_W-1:0] im;
  } bin_t;

endpackage

// File: rtl/fft_bin_ram.sv
// N x 2W bin storage: independent real/imag write enables, one registered read port.
module fft_bin_ram
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we_re,
  input  logic              i_we_im,
  input  logic [FFT_AW-1:0] i_waddr,
  input  bin_t              i_wdata,
  input  logic              i_rd_en,
  input  logic [FFT_AW-1:0] i_raddr,
  output bin_t              o_rdata
);

  logic [FFT_OUT_W-1:0] r_mem_re [FFT_N];
  logic [FFT_OUT_W-1:0] r_mem_im [FFT_N];
  bin_t                 r_rdata;

  // Storage itself is not reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (i_we_re) r_mem_re[i_waddr] <= i_wdata.re;
    if (i_we_im) r_mem_im[i_waddr] <= i_wdata.im;
  end

  // Read data holds its last value when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_rd_en) begin
      r_rdata.re <= r_mem_re[i_raddr];
      r_rdata.im <= r_mem_im[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_result_collector.sv
// Captures a serial FFT result frame (N real then N imag words) and holds it for
// random-access readout until the consumer clears it.
module fft_result_collector
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 finish_i,
  input  logic [FFT_OUT_W-1:0] answer_i,
  input  logic                 clr_i,
  input  logic                 rd_en_i,
  input  logic [FFT_AW-1:0]    rd_addr_i,
  output logic                 rd_valid_o,
  output logic [FFT_OUT_W-1:0] rd_re_o,
  output logic [FFT_OUT_W-1:0] rd_im_o,
  output logic                 frame_done_o,
  output logic                 busy_o,
  output logic                 overrun_o,
  output logic                 abort_o
);

  localparam logic [FFT_AW-1:0]    LAST_IDX = FFT_AW'(FFT_N - 1);
  localparam logic [FFT_GAP_W-1:0] GAP_LAST = FFT_GAP_W'(FFT_GAP_MAX - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [FFT_AW-1:0]     r_cnt;
  logic [FFT_AW-1:0]     w_cnt_nxt;
  logic [FFT_GAP_W-1:0]  r_gap;
  logic [FFT_GAP_W-1:0]  w_gap_nxt;
  logic [FFT_AW-1:0]     w_waddr;
  logic                  w_we_re;
  logic                  w_we_im;
  logic                  w_rd_acc;
  logic                  w_set_ovr;
  logic                  w_set_abort;
  logic                  r_rd_valid;
  logic                  r_done;
  logic                  r_busy;
  logic                  r_ovr;
  logic                  r_abort;
  bin_t                  w_wdata;
  bin_t                  w_rdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_waddr     = r_cnt;
    w_we_re     = 1'b0;
    w_we_im     = 1'b0;
    w_rd_acc    = 1'b0;
    w_set_ovr   = 1'b0;
    w_set_abort = 1'b0;
    case (r_state)
      IDLE: begin
        w_waddr = '0;
        if (finish_i) begin
          w_we_re     = 1'b1;
          w_cnt_nxt   = FFT_AW'(1);
          w_gap_nxt   = '0;
          w_state_nxt = CAP_RE;
        end
      end
      CAP_RE, CAP_IM: begin
        if (finish_i) begin
          w_we_re   = (r_state == CAP_RE);
          w_we_im   = (r_state == CAP_IM);
          w_gap_nxt = '0;
          w_cnt_nxt = r_cnt + FFT_AW'(1);
          if (r_cnt == LAST_IDX)
            w_state_nxt = (r_state == CAP_RE) ? CAP_IM : DONE;
        end else if (r_gap == GAP_LAST) begin
          // Gap timeout: drop the partial frame.
          w_set_abort = 1'b1;
          w_cnt_nxt   = '0;
          w_gap_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_gap_nxt = r_gap + FFT_GAP_W'(1);
        end
      end
      DONE: begin
        // Memory is frozen; late words are dropped and flagged, clear wins.
        w_rd_acc  = rd_en_i;
        w_set_ovr = finish_i;
        if (clr_i) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_gap      <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_ovr      <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_gap      <= w_gap_nxt;
      r_rd_valid <= w_rd_acc;
      r_done     <= (w_state_nxt == DONE);
      r_busy     <= (w_state_nxt == CAP_RE) || (w_state_nxt == CAP_IM);
      r_ovr      <= r_ovr | w_set_ovr;
      r_abort    <= r_abort | w_set_abort;
    end
  end

  assign w_wdata.re = answer_i;
  assign w_wdata.im = answer_i;

  fft_bin_ram u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we_re (w_we_re),
    .i_we_im (w_we_im),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_rd_en (w_rd_acc),
    .i_raddr (rd_addr_i),
    .o_rdata (w_rdata)
  );

  assign rd_valid_o   = r_rd_valid;
  assign rd_re_o      = w_rdata.re;
  assign rd_im_o      = w_rdata.im;
  assign frame_done_o = r_done;
  assign busy_o       = r_busy;
  assign overrun_o    = r_ovr;
  assign abort_o      = r_abort;

endmodule
